// File: rtl/gpu_pkg.sv
// Shared GPU definitions: shared-memory geometry, arbiter state encoding
// and the memory opcodes used by integration benches.
package gpu_pkg;

    localparam int unsigned SMEM_ADDR_W = 12;
    localparam int unsigned SMEM_DATA_W = 8;

    // Shared-memory arbiter sequencing states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ISSUE  = 2'd1,
        RDWAIT = 2'd2,
        RESP   = 2'd3
    } arb_state_e;

    localparam logic [3:0] OP_LD = 4'd11;
    localparam logic [3:0] OP_ST = 4'd13;

endpackage

// File: rtl/rr_pick.sv
// Round-robin winner select (combinational).
// Ports:
//   req_i   - request vector, one bit per requester
//   ptr_i   - highest-priority index this round (must be < N)
//   found_o - at least one request is pending
//   idx_o   - first requester at or after ptr_i, with wrap-around
module rr_pick #(
    parameter int unsigned N     = 8,
    parameter int unsigned IDX_W = 4
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             found_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W:0] cand;

    // Scan offsets from the far end down so the nearest hit to ptr_i wins.
    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        cand    = '0;
        for (int unsigned i = N; i > 0; i--) begin
            cand = {1'b0, ptr_i} + (IDX_W+1)'(i - 1);
            if (cand >= (IDX_W+1)'(N)) begin
                cand = cand - (IDX_W+1)'(N);
            end
            if ((req_i & (N'(1) << cand[IDX_W-1:0])) != '0) begin
                found_o = 1'b1;
                idx_o   = cand[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/smem_arbiter.sv
// Round-robin arbiter between N cores and the single-port shared memory.
// Ports:
//   clk, reset              - clock, async active-low reset
//   core_req/we/addr/wdata  - per-core level requests (packed per core)
//   core_val                - one-hot done pulse to the served core
//   core_rdata              - last load data, broadcast
//   grant_id, busy          - current owner (0 when idle), not-idle flag
//   sm_en/we/addr/wdata     - SRAM access port
//   sm_rdata                - SRAM read data, one cycle after a read edge
module smem_arbiter
    import gpu_pkg::*;
#(
    parameter int unsigned N_CORES = 8,
    parameter int unsigned ADDR_W  = SMEM_ADDR_W,
    parameter int unsigned DATA_W  = SMEM_DATA_W,
    parameter int unsigned ID_W    = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [N_CORES-1:0]        core_req,
    input  logic [N_CORES-1:0]        core_we,
    input  logic [N_CORES*ADDR_W-1:0] core_addr,
    input  logic [N_CORES*DATA_W-1:0] core_wdata,
    output logic [N_CORES-1:0]        core_val,
    output logic [DATA_W-1:0]         core_rdata,
    output logic [ID_W-1:0]           grant_id,
    output logic                      busy,
    output logic                      sm_en,
    output logic                      sm_we,
    output logic [ADDR_W-1:0]         sm_addr,
    output logic [DATA_W-1:0]         sm_wdata,
    input  logic [DATA_W-1:0]         sm_rdata
);

    arb_state_e          state_q, state_d;
    logic [ID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic [ID_W-1:0]     grant_q, grant_d;
    logic                busy_q, busy_d;
    logic [N_CORES-1:0]  val_q, val_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                sm_en_q, sm_en_d;
    logic                sm_we_q, sm_we_d;
    logic [ADDR_W-1:0]   sm_addr_q, sm_addr_d;
    logic [DATA_W-1:0]   sm_wdata_q, sm_wdata_d;

    logic                     pick_found;
    logic [ID_W-1:0]          pick_idx;
    logic [N_CORES-1:0]       we_sh;
    logic [N_CORES*ADDR_W-1:0] addr_sh;
    logic [N_CORES*DATA_W-1:0] wdata_sh;
    logic [N_CORES-1:0]       grant_onehot;

    rr_pick #(
        .N     (N_CORES),
        .IDX_W (ID_W)
    ) u_pick (
        .req_i   (core_req),
        .ptr_i   (rr_ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    // Winner's request fields, shifted down to slot 0
    assign we_sh        = core_we >> pick_idx;
    assign addr_sh      = core_addr >> (int'(pick_idx) * ADDR_W);
    assign wdata_sh     = core_wdata >> (int'(pick_idx) * DATA_W);
    assign grant_onehot = N_CORES'(1) << grant_q;

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        busy_d     = busy_q;
        val_d      = '0;
        rdata_d    = rdata_q;
        sm_en_d    = sm_en_q;
        sm_we_d    = sm_we_q;
        sm_addr_d  = sm_addr_q;
        sm_wdata_d = sm_wdata_q;
        case (state_q)
            IDLE: begin
                sm_en_d = 1'b0;
                if (pick_found) begin
                    grant_d    = pick_idx;
                    busy_d     = 1'b1;
                    sm_en_d    = 1'b1;
                    sm_we_d    = we_sh[0];
                    sm_addr_d  = addr_sh[ADDR_W-1:0];
                    sm_wdata_d = wdata_sh[DATA_W-1:0];
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                sm_en_d = 1'b0;
                sm_we_d = 1'b0;
                // sm_we_q still holds the latched op during this cycle
                if (sm_we_q) begin
                    val_d   = grant_onehot;
                    state_d = RESP;
                end else begin
                    state_d = RDWAIT;
                end
            end
            RDWAIT: begin
                rdata_d = sm_rdata;
                val_d   = grant_onehot;
                state_d = RESP;
            end
            RESP: begin
                rr_ptr_d = (grant_q == ID_W'(N_CORES - 1)) ? '0 : grant_q + ID_W'(1);
                grant_d  = '0;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            busy_q     <= 1'b0;
            val_q      <= '0;
            rdata_q    <= '0;
            sm_en_q    <= 1'b0;
            sm_we_q    <= 1'b0;
            sm_addr_q  <= '0;
            sm_wdata_q <= '0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            busy_q     <= busy_d;
            val_q      <= val_d;
            rdata_q    <= rdata_d;
            sm_en_q    <= sm_en_d;
            sm_we_q    <= sm_we_d;
            sm_addr_q  <= sm_addr_d;
            sm_wdata_q <= sm_wdata_d;
        end
    end

    assign core_val   = val_q;
    assign core_rdata = rdata_q;
    assign grant_id   = grant_q;
    assign busy       = busy_q;
    assign sm_en      = sm_en_q;
    assign sm_we      = sm_we_q;
    assign sm_addr    = sm_addr_q;
    assign sm_wdata   = sm_wdata_q;

endmodule

// File: tb/tb_smem_arbiter.sv
// Self-checking bench for smem_arbiter: table of single transactions plus
// directed contention, fairness, mid-op reset and late-input sequences.
module tb_smem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  core_req, core_we, core_val;
    logic [95:0] core_addr;
    logic [63:0] core_wdata;
    logic [7:0]  core_rdata, sm_wdata, sm_rdata;
    logic [3:0]  grant_id;
    logic        busy, sm_en, sm_we;
    logic [11:0] sm_addr;

    int n_pass = 0;
    int n_tot  = 0;
    int cyc    = 0;

    logic [7:0] mem [4096];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous single-port SRAM model
    always @(posedge clk) begin
        if (sm_en) begin
            if (sm_we) mem[sm_addr] <= sm_wdata;
            else       sm_rdata     <= mem[sm_addr];
        end
    end

    smem_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .core_req   (core_req),
        .core_we    (core_we),
        .core_addr  (core_addr),
        .core_wdata (core_wdata),
        .core_val   (core_val),
        .core_rdata (core_rdata),
        .grant_id   (grant_id),
        .busy       (busy),
        .sm_en      (sm_en),
        .sm_we      (sm_we),
        .sm_addr    (sm_addr),
        .sm_wdata   (sm_wdata),
        .sm_rdata   (sm_rdata)
    );

    typedef struct {
        int         core;
        logic       we;
        logic [11:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rd;
    } vec_t;

    vec_t vecs [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input int k, input logic we, input logic [11:0] a, input logic [7:0] d);
        core_we[k[2:0]]       = we;
        core_addr[k*12 +: 12] = a;
        core_wdata[k*8 +: 8]  = d;
        core_req[k[2:0]]      = 1'b1;
    endtask

    // Wait (bounded) for a done pulse; the requester drops its request on
    // the edge that ends the pulse cycle.
    task automatic wait_val(input string nm, output logic [7:0] v, output int at);
        bit seen = 0;
        v  = '0;
        at = -1;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (core_val != 8'h00) begin
                v    = core_val;
                at   = cyc;
                seen = 1;
            end
            tick();
        end
        if (seen) core_req = core_req & ~v;
        else begin
            n_tot++;
            $display("FAIL %s: timeout, got no core_val expected a pulse", nm);
        end
    endtask

    task automatic do_reset();
        core_req   = '0;
        core_we    = '0;
        core_addr  = '0;
        core_wdata = '0;
        reset      = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] v;
        int at, prev_at, t_rel;
        int k;
        logic [7:0] exp_order [3];
        logic [7:0] exp_rd [3];

        for (int i = 0; i < 4096; i++) mem[i] = 8'(i * 3 + 7);
        mem[12'h123] = 8'h5A;
        sm_rdata = '0;

        vecs[0] = '{3, 1'b0, 12'h123, 8'h00, 8'h5A};
        vecs[1] = '{0, 1'b1, 12'hFFF, 8'hC3, 8'h5A};
        vecs[2] = '{5, 1'b0, 12'hFFF, 8'h00, 8'hC3};
        vecs[3] = '{2, 1'b1, 12'h000, 8'h11, 8'hC3};
        vecs[4] = '{6, 1'b0, 12'h000, 8'h00, 8'h11};
        vecs[5] = '{1, 1'b0, 12'h123, 8'h00, 8'h5A};

        // Reset state
        core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
        reset = 1'b0;
        tick();
        chk("rst_val",   32'(core_val),   32'h0);
        chk("rst_rdata", 32'(core_rdata), 32'h0);
        chk("rst_grant", 32'(grant_id),   32'h0);
        chk("rst_busy",  32'(busy),       32'h0);
        chk("rst_sm_en", 32'(sm_en),      32'h0);
        chk("rst_sm_we", 32'(sm_we),      32'h0);
        chk("rst_addr",  32'(sm_addr),    32'h0);
        chk("rst_wdata", 32'(sm_wdata),   32'h0);
        reset = 1'b1;
        tick();

        // Table of isolated transactions, cycle-exact
        for (int i = 0; i < 6; i++) begin
            k = vecs[i].core;
            set_core(k, vecs[i].we, vecs[i].addr, vecs[i].wdata);
            tick();
            chk("t1_sm_en",  32'(sm_en),    32'h1);
            chk("t1_sm_we",  32'(sm_we),    32'(vecs[i].we));
            chk("t1_addr",   32'(sm_addr),  32'(vecs[i].addr));
            if (vecs[i].we) chk("t1_wdata", 32'(sm_wdata), 32'(vecs[i].wdata));
            chk("t1_grant",  32'(grant_id), 32'(k));
            chk("t1_busy",   32'(busy),     32'h1);
            if (!vecs[i].we) begin
                tick();
                chk("rdwait_val", 32'(core_val), 32'h0);
                chk("rdwait_en",  32'(sm_en),    32'h0);
            end
            tick();
            chk("val_onehot", 32'(core_val),   32'(8'(1) << k));
            chk("val_rdata",  32'(core_rdata), 32'(vecs[i].exp_rd));
            chk("val_grant",  32'(grant_id),   32'(k));
            tick();
            core_req[k[2:0]] = 1'b0;
            chk("idle_val",   32'(core_val), 32'h0);
            chk("idle_grant", 32'(grant_id), 32'h0);
            chk("idle_busy",  32'(busy),     32'h0);
        end

        // Contention: 1, 4, 6 together from rr_ptr=0
        do_reset();
        exp_order = '{8'h02, 8'h10, 8'h40};
        exp_rd    = '{8'h37, 8'h67, 8'h97};
        set_core(1, 1'b0, 12'h010, 8'h00);
        set_core(4, 1'b0, 12'h020, 8'h00);
        set_core(6, 1'b0, 12'h030, 8'h00);
        prev_at = 0;
        for (int i = 0; i < 3; i++) begin
            wait_val("cont_wait", v, at);
            chk("cont_order", 32'(v),          32'(exp_order[i]));
            chk("cont_rdata", 32'(core_rdata), 32'(exp_rd[i]));
            if (i > 0) chk("cont_spacing", 32'(at - prev_at), 32'd4);
            prev_at = at;
        end
        // rr_ptr is now 7: core 7 beats core 0, then wraps to 0
        set_core(0, 1'b1, 12'h100, 8'hAA);
        set_core(7, 1'b1, 12'h101, 8'hBB);
        wait_val("ptr7_wait", v, at);
        chk("ptr7_first", 32'(v), 32'h80);
        prev_at = at;
        wait_val("ptr7_wait2", v, at);
        chk("ptr7_second",   32'(v),            32'h01);
        chk("store_spacing", 32'(at - prev_at), 32'd3);

        // Fairness: all cores requesting continuously for 16 transactions
        do_reset();
        for (int j = 0; j < 8; j++) set_core(j, 1'b0, 12'(12'h200 + j), 8'h00);
        prev_at = 0;
        for (int i = 0; i < 16; i++) begin
            wait_val("fair_wait", v, at);
            chk("fair_order", 32'(v),          32'(8'(1) << (i % 8)));
            chk("fair_rdata", 32'(core_rdata), 32'(8'(7 + 3 * (i % 8))));
            if (i > 0) chk("fair_spacing", 32'(at - prev_at), 32'd4);
            prev_at = at;
            core_req[3'(i % 8)] = 1'b1;
        end

        // Mid-op reset during RDWAIT abandons the load
        do_reset();
        set_core(2, 1'b0, 12'h123, 8'h00);
        tick();
        tick();
        chk("mid_grant", 32'(grant_id), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("mid_async_val",   32'(core_val), 32'h0);
        chk("mid_async_grant", 32'(grant_id), 32'h0);
        chk("mid_async_busy",  32'(busy),     32'h0);
        chk("mid_async_en",    32'(sm_en),    32'h0);
        chk("mid_async_addr",  32'(sm_addr),  32'h0);
        tick();
        chk("mid_hold_val", 32'(core_val), 32'h0);
        reset = 1'b1;
        t_rel = cyc;
        wait_val("mid_retry", v, at);
        chk("mid_retry_val",   32'(v),           32'h04);
        chk("mid_retry_rdata", 32'(core_rdata),  32'h5A);
        chk("mid_retry_lat",   32'(at - t_rel),  32'd3);

        // Granted core's inputs change after grant: latched values used
        set_core(7, 1'b0, 12'h010, 8'h00);
        tick();
        core_addr[7*12 +: 12] = 12'h020;
        core_we[7]            = 1'b1;
        chk("late_addr_issue", 32'(sm_addr), 32'h010);
        chk("late_we_issue",   32'(sm_we),   32'h0);
        tick();
        chk("late_addr_hold",  32'(sm_addr), 32'h010);
        wait_val("late_wait", v, at);
        chk("late_val",   32'(v),          32'h80);
        chk("late_rdata", 32'(core_rdata), 32'h37);
        chk("late_mem",   32'(mem[12'h020]), 32'h67);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule

// File: doc/smem_arbiter.md
Name: smem_arbiter

Overview:
- Sits between N gpu cores and the single-port shared memory (4096 x 8).
- Each core raises a level request with a 12-bit address. It holds the request until it sees a one-cycle valid pulse.
- The block grants one core at a time in round-robin order, sequences the SRAM access and returns read data or a store acknowledge to the granted core only.

Parameters:
- N_CORES, 8, number of requesting cores (2..16)
- ADDR_W, 12, shared-memory address width
- DATA_W, 8, data width
- ID_W, 4, width of grant_id; must satisfy 2**ID_W >= N_CORES

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- core_req  in  N_CORES  per-core memory request, level, held until served
- core_we  in  N_CORES  per-core 1=store, 0=load; valid while core_req is high
- core_addr  in  N_CORES*ADDR_W  packed addresses; core k at [k*ADDR_W +: ADDR_W]
- core_wdata  in  N_CORES*DATA_W  packed store data; core k at [k*DATA_W +: DATA_W]
- core_val  out  N_CORES  one-hot one-cycle done pulse (val_data of core k)
- core_rdata  out  DATA_W  load data, broadcast to all cores; meaningful when core_val[k] is high
- grant_id  out  ID_W  index of core currently owned; 0 when idle
- busy  out  1  high in any state other than IDLE
- sm_en  out  1  SRAM access enable
- sm_we  out  1  SRAM write enable
- sm_addr  out  ADDR_W  SRAM address
- sm_wdata  out  DATA_W  SRAM write data
- sm_rdata  in  DATA_W  SRAM read data, valid one cycle after an enabled read edge

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, rr_ptr=0, grant_id=0, busy=0
  - core_val=0, core_rdata=0
  - sm_en=0, sm_we=0, sm_addr=0, sm_wdata=0
  - Reset asserted mid-transaction abandons it: no core_val is ever issued for it, and the requester keeps core_req high and is re-arbitrated after reset.
- All outputs are registered.
- FSM states: IDLE, ISSUE, RDWAIT, RESP.
- IDLE:
  - If any core_req bit is high, pick the first requester scanning from rr_ptr upward with wrap-around: rr_ptr, rr_ptr+1, ..., N_CORES-1, 0, ...
  - Latch grant_id, and latch that core's we, addr and wdata into sm_* regs.
  - Set sm_en=1 and go to ISSUE.
  - If no request, stay in IDLE with sm_en=0.
- ISSUE (SRAM sees the access on this edge):
  - Set sm_en=0 and sm_we=0.
  - Store: go to RESP.
  - Load: go to RDWAIT.
- RDWAIT: capture sm_rdata into core_rdata, then go to RESP.
- RESP:
  - core_val[grant_id]=1 for exactly this cycle.
  - rr_ptr = grant_id+1, wrapping to 0 at N_CORES.
  - Go to IDLE. On leaving, core_val returns to 0 and grant_id to 0.
- Latency, with the request first sampled in the IDLE cycle T:
  - Load: core_val high in cycle T+3.
  - Store: core_val high in cycle T+2.
  - Minimum spacing between grants is 4 cycles (load) or 3 cycles (store).
- Requester contract: a core drops core_req on the clock edge where it samples core_val high. The following IDLE cycle therefore never re-grants the same request.
- Request inputs are sampled only in IDLE.
  - Changes to a non-granted core's request during a transaction are ignored until the next IDLE.
  - Changes to the granted core's addr/we/wdata after the grant have no effect, because the values were latched.
- Simultaneous requests: exactly one grant per transaction. The others stay pending and are never lost.
- Fairness: with all N_CORES requesting continuously, each core is served exactly once per N_CORES transactions.
- core_rdata holds its last value after a load. Stores do not modify it.
- Requester indices >= N_CORES do not exist. rr_ptr never takes a value >= N_CORES.

Decomposition:
- Shared package gpu_pkg holds:
  - localparams SMEM_ADDR_W=12 and SMEM_DATA_W=8
  - the arbiter state encoding: IDLE=0, ISSUE=1, RDWAIT=2, RESP=3
  - the opcode constants OP_LD=11 and OP_ST=13, used by integration benches
- One sub-module, rr_pick: purely combinational.
  - Inputs: request vector and rr_ptr.
  - Outputs: found flag and winner index (masked-priority plus wrap).
  - All sequencing stays in smem_arbiter.

Test Plan:
- Single load: the SRAM model holds 0x5A at 0x123. Core 3 asserts req, we=0, addr=0x123 in cycle T -> sm_en=1, sm_addr=0x123 in T+1; core_val=8'b0000_1000 and core_rdata=0x5A in T+3; grant_id=3 throughout.
- Single store: core 0 stores 0xC3 to 0xFFF -> sm_we=1, sm_wdata=0xC3 in T+1; core_val[0] pulses in T+2. A following load from 0xFFF by core 5 returns 0xC3.
- Contention: cores 1, 4 and 6 request loads in the same cycle with rr_ptr=0 -> served in order 1, 4, 6 with val pulses 4 cycles apart; rr_ptr ends at 7.
- Fairness wrap: all 8 cores hold requests continuously for 16 transactions -> grant sequence 0..7,0..7, with no core served twice before all others are served once.
- Reset mid-op: core 2 load granted, reset=0 during RDWAIT -> all outputs 0 immediately (asynchronously), no core_val[2]. After release, core 2 (still requesting) is granted with rr_ptr=0 and completes normally.
- Ignored late inputs: after core 7 is granted for addr 0x010, the bench changes core_addr[7] to 0x020 -> sm_addr stays 0x010.
